// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns, bit order g..a, indexed by hex value
  localparam logic [6:0] SEG_HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port: valid/ready handshake carrying digit index, hex value and decimal point.
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDXW = $clog2(NUM_DIGITS);

  logic            wr_valid;
  logic            wr_ready;
  logic [IDXW-1:0] wr_digit;
  logic [3:0]      wr_data;
  logic            wr_dp;

  modport master (output wr_valid, wr_digit, wr_data, wr_dp, input wr_ready);
  modport slave  (input wr_valid, wr_digit, wr_data, wr_dp, output wr_ready);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex to active-low 7-segment lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_n_c
);
  assign o_seg_n_c = SEG_HEX_LUT[i_hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-boundary commit of written digits.
// Optional per-digit blinking is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS   = 4,
  parameter  int unsigned PRESCALE     = 50000,
  parameter  int unsigned BLANK_CYCLES = 16,
  parameter  int unsigned BLINK_DIV    = 25000000,
  localparam int unsigned IDXW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        wr,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [IDXW-1:0]       scan_idx,
  output logic                  frame_tick
);

  localparam int unsigned CNTW = $clog2(PRESCALE);
  localparam int unsigned SHOW_CYCLES = PRESCALE - BLANK_CYCLES;

  scan_state_t           r_state;
  logic [CNTW-1:0]       r_cnt;
  logic [IDXW-1:0]       r_idx;
  digit_t                r_shadow [NUM_DIGITS];
  digit_t                r_active [NUM_DIGITS];
  logic                  r_dirty;
  logic                  r_wr_ready;
  logic                  r_frame_tick;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  digit_t     w_cur;
  logic [6:0] w_seg_c;
  logic       w_blank_c;
  logic       w_wr_hit;

  assign w_cur    = r_active[r_idx];
  assign w_wr_hit = wr.wr_valid & r_wr_ready & (32'(wr.wr_digit) < NUM_DIGITS);

  seg_hex_decode u_dec (
    .i_hex     (w_cur.hex),
    .o_seg_n_c (w_seg_c)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned BLKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLKW-1:0] r_blink_cnt;
  logic            r_phase;

  // Free-running blink phase; masked digits go dark while the phase is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BLKW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLKW'(1);
    end
  end

  assign w_blank_c = blink_mask[r_idx] & ~r_phase;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{blink_mask, BLINK_DIV};
  assign w_blank_c      = 1'b0;
`endif

  // Scan FSM, write port and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '{default: '0};
      r_active     <= '{default: '0};
      r_dirty      <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
    end else begin
      r_wr_ready   <= 1'b1;
      r_frame_tick <= 1'b0;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;

      // Commit happens before the write so a coincident write stays pending
      if (r_frame_tick && r_dirty) begin
        r_active <= r_shadow;
        r_dirty  <= 1'b0;
      end
      if (w_wr_hit) begin
        r_shadow[wr.wr_digit] <= '{dp: wr.wr_dp, hex: wr.wr_data};
        r_dirty               <= 1'b1;
      end

      if (!enable) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
          ST_BLANK: begin
            r_seg_n <= w_blank_c ? SEG_OFF : w_seg_c;
            r_dp_n  <= w_blank_c | ~w_cur.dp;
            if (r_cnt == CNTW'(BLANK_CYCLES - 1)) begin
              r_state <= ST_SHOW;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
          ST_SHOW: begin
            r_seg_n <= w_blank_c ? SEG_OFF : w_seg_c;
            r_dp_n  <= w_blank_c | ~w_cur.dp;
            r_an_n  <= ~(NUM_DIGITS'(1) << r_idx);
            if (r_cnt == CNTW'(SHOW_CYCLES - 1)) begin
              r_state <= ST_BLANK;
              r_cnt   <= '0;
              if (r_idx == IDXW'(NUM_DIGITS - 1)) begin
                r_idx        <= '0;
                r_frame_tick <= 1'b1;
              end else begin
                r_idx <= r_idx + IDXW'(1);
              end
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr.wr_ready = r_wr_ready;
  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign an_n        = r_an_n;
  assign scan_idx    = r_idx;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a position-based display model.
module tb_seg_scan_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned P     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned BD    = 20;
  localparam int unsigned IDXW  = 2;
  localparam int unsigned FRAME = N * P;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic [N-1:0]    blink_mask;
  logic [6:0]      seg_n;
  logic            dp_n;
  logic [N-1:0]    an_n;
  logic [IDXW-1:0] scan_idx;
  logic            frame_tick;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) wr_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr_if),
    .blink_mask(blink_mask), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .scan_idx(scan_idx), .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] w_obs;
  assign w_obs = {seg_n, dp_n, an_n, scan_idx, frame_tick, wr_if.wr_ready};

  // Model state: scan position counts cycles since the scan started
  logic [4:0]  m_shadow [N];
  logic [4:0]  m_active [N];
  bit          m_dirty, m_ready, m_run;
  int          m_pos, m_cyc;
  logic [15:0] e_all;
  logic [15:0] off_val;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    string      lit;
    logic [6:0] r;
    r = 7'h7F;
    case (v)
      4'h0: lit = "abcdef";   4'h1: lit = "bc";      4'h2: lit = "abdeg";  4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";     4'h5: lit = "acdfg";   4'h6: lit = "acdefg"; 4'h7: lit = "abc";
      4'h8: lit = "abcdefg";  4'h9: lit = "abcdfg";  4'hA: lit = "abcefg"; 4'hB: lit = "cdefg";
      4'hC: lit = "adef";     4'hD: lit = "bcdeg";   4'hE: lit = "adefg";  default: lit = "aefg";
    endcase
    for (int i = 0; i < lit.len(); i++) r[int'(lit[i]) - 97] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_dirty = 0; m_ready = 0; m_run = 0; m_pos = 0; m_cyc = 0;
  endtask

  // Advance one clock and update the model from the inputs held across that edge
  task automatic step();
    bit         tick_pre, ph, blk;
    int         s, off;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    logic [N-1:0]    e_an;
    logic [IDXW-1:0] e_idx;
    @(posedge clk);
    tick_pre = m_run && m_pos > 0 && (m_pos % FRAME) == 0;
    ph = ((m_cyc / BD) % 2) == 0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_idx = '0; e_tick = 1'b0;
    if (enable && m_run) begin
      s   = (m_pos / P) % N;
      off = m_pos % P;
`ifdef SEG_SCAN_BLINK_EN
      blk = blink_mask[s] && !ph;
`else
      blk = 1'b0;
`endif
      e_seg = blk ? 7'h7F : seg_of(m_active[s][3:0]);
      e_dp  = blk | ~m_active[s][4];
      if (off >= B) e_an = ~(N'(1) << s);
      e_idx  = IDXW'(((m_pos + 1) / P) % N);
      e_tick = ((m_pos + 1) % FRAME) == 0;
    end
    if (tick_pre && m_dirty) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      m_dirty = 0;
    end
    if (wr_if.wr_valid && m_ready && int'(wr_if.wr_digit) < N) begin
      m_shadow[wr_if.wr_digit] = {wr_if.wr_dp, wr_if.wr_data};
      m_dirty = 1;
    end
    m_ready = 1;
    if (!enable) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0;
    end else begin
      m_pos++;
    end
    m_cyc++;
    e_all = {e_seg, e_dp, e_an, e_idx, e_tick, m_ready};
    #1;
  endtask

  task automatic do_write(input int d, input logic [3:0] v, input logic dp);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_digit = IDXW'(d);
    wr_if.wr_data  = v;
    wr_if.wr_dp    = dp;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; blink_mask = '0;
    wr_if.wr_valid = 1'b0; wr_if.wr_digit = '0; wr_if.wr_data = '0; wr_if.wr_dp = 1'b0;
    off_val = {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0};
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (w_obs !== off_val) begin n_fail++; $display("FAIL reset_async got %h exp %h", w_obs, off_val); end
    @(posedge clk); #1;
    n_tests++;
    if (w_obs !== off_val) begin n_fail++; $display("FAIL reset_hold got %h exp %h", w_obs, off_val); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    n_tests++;
    if (w_obs !== e_all) begin n_fail++; $display("FAIL reset_release got %h exp %h", w_obs, e_all); end
    n_tests++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after_reset got %b exp 1", wr_if.wr_ready); end
  endtask

  task automatic test_scan();
    logic [N-1:0] walk [$];
    logic [N-1:0] exp_walk [4];
    logic [N-1:0] prev_an;
    int ticks = 0;
    bit seen_e = 0;
    exp_walk = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int d = 0; d < 4; d++) do_write(d, 4'(d + 1), 1'b0);
    enable = 1'b1;
    prev_an = an_n;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL scan_cyc t=%0t got %h exp %h", $time, w_obs, e_all); end
      if (frame_tick) ticks++;
      if (ticks > 0 && an_n !== prev_an && an_n !== 4'hF && walk.size() < 4) walk.push_back(an_n);
      if (ticks > 0 && an_n === 4'hE && !seen_e) begin
        seen_e = 1;
        n_tests++;
        if (seg_n !== 7'b1111001) begin n_fail++; $display("FAIL scan_digit0_seg got %b exp 1111001", seg_n); end
      end
      prev_an = an_n;
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= walk.size()) begin
        n_fail++; $display("FAIL scan_walk[%0d] got none exp %h", i, exp_walk[i]);
      end else if (walk[i] !== exp_walk[i]) begin
        n_fail++; $display("FAIL scan_walk[%0d] got %h exp %h", i, walk[i], exp_walk[i]);
      end
    end
  endtask

  task automatic test_midframe_write();
    int ticks = 0;
    logic [6:0] exp_seg;
    for (int k = 0; k < 2 * FRAME && scan_idx !== 2'd1; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL mid_wait t=%0t got %h exp %h", $time, w_obs, e_all); end
    end
    do_write(2, 4'hF, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL mid_cyc t=%0t got %h exp %h", $time, w_obs, e_all); end
      if (frame_tick) ticks++;
      if (an_n === 4'hB) begin
        exp_seg = (ticks == 0) ? 7'b0110000 : 7'b0001110;
        n_tests++;
        if (seg_n !== exp_seg) begin n_fail++; $display("FAIL mid_digit2 ticks=%0d got %b exp %b", ticks, seg_n, exp_seg); end
      end
    end
  endtask

  task automatic test_coincident_write();
    int ticks = 0;
    bit found = 0;
    for (int k = 0; k < 2 * FRAME && scan_idx !== 2'd1; k++) step();
    do_write(0, 4'h5, 1'b1);
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL coin_wait t=%0t got %h exp %h", $time, w_obs, e_all); end
      found = (frame_tick === 1'b1);
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL coin_tick_timeout got 0 exp 1"); end
    do_write(1, 4'hA, 1'b0);
    n_tests++;
    if (w_obs !== e_all) begin n_fail++; $display("FAIL coin_write t=%0t got %h exp %h", $time, w_obs, e_all); end
    for (int k = 0; k < 2 * FRAME + P; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL coin_cyc t=%0t got %h exp %h", $time, w_obs, e_all); end
      if (frame_tick) ticks++;
      if (ticks == 0 && an_n === 4'hE) begin
        n_tests++;
        if ({seg_n, dp_n} !== {7'b0010010, 1'b0}) begin n_fail++; $display("FAIL coin_d0 got %b/%b exp 0010010/0", seg_n, dp_n); end
      end
      if (an_n === 4'hD && ticks < 2) begin
        n_tests++;
        if (seg_n !== (ticks == 0 ? 7'b0100100 : 7'b0001000)) begin
          n_fail++; $display("FAIL coin_d1 ticks=%0d got %b", ticks, seg_n);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int nf = 0;
    for (int k = 0; k < 2 * FRAME && an_n !== 4'hB; k++) step();
    n_tests++;
    if (an_n !== 4'hB) begin n_fail++; $display("FAIL drop_wait got %h exp b", an_n); end
    enable = 1'b0;
    step();
    n_tests++;
    if (an_n !== 4'hF) begin n_fail++; $display("FAIL drop_an got %h exp f", an_n); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL drop_idle t=%0t got %h exp %h", $time, w_obs, e_all); end
    end
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL drop_restart t=%0t got %h exp %h", $time, w_obs, e_all); end
      if (an_n !== 4'hF) break;
      nf++;
    end
    n_tests++;
    if (nf != 3 || an_n !== 4'hE) begin n_fail++; $display("FAIL drop_gap got %0d/%h exp 3/e", nf, an_n); end
  endtask

  task automatic test_random();
    blink_mask = 4'b0001;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if (k == 750) blink_mask = 4'($urandom());
      if ($urandom_range(0, 3) == 0) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = IDXW'($urandom_range(0, N - 1));
        wr_if.wr_data  = 4'($urandom());
        wr_if.wr_dp    = 1'($urandom());
      end else begin
        wr_if.wr_valid = 1'b0;
      end
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL rand t=%0t got %h exp %h", $time, w_obs, e_all); end
    end
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (w_obs !== off_val) begin n_fail++; $display("FAIL rst_mid got %h exp %h", w_obs, off_val); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      n_tests++;
      if (w_obs !== e_all) begin n_fail++; $display("FAIL rst_mid_cyc t=%0t got %h exp %h", $time, w_obs, e_all); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_midframe_write();
    test_coincident_write();
    test_enable_drop();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one active-low segment bus. It holds a hex value and a decimal-point bit per digit, writable through a valid/ready port, and cycles the digit enables at a fixed refresh rate. A blanking gap is inserted between digits to suppress ghosting. New values are committed only at frame boundaries, so a partially written display never appears.

Parameters:
NUM_DIGITS, 4, number of scanned digits (2..8)
PRESCALE, 50000, clock cycles per digit slot, blank gap included
BLANK_CYCLES, 16, cycles with all anodes off at the start of each slot; must satisfy 1 <= BLANK_CYCLES < PRESCALE
BLINK_DIV, 25000000, cycles per blink half-period (used only with SEG_SCAN_BLINK_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan enable; 0 blanks the display
wr_valid  in  1  write request
wr_ready  out  1  write accepted when valid&ready
wr_digit  in  IDXW=$clog2(NUM_DIGITS)  target digit index
wr_data  in  4  hex value 0..F
wr_dp  in  1  decimal point, 1 = lit
blink_mask  in  NUM_DIGITS  per-digit blink enable (ignored without SEG_SCAN_BLINK_EN)
seg_n  out  7  segments, active-low; [0]=a ... [6]=g
dp_n  out  1  decimal point, active-low
an_n  out  NUM_DIGITS  digit enables, active-low
scan_idx  out  IDXW  digit currently driven
frame_tick  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (async, rst_n=0): seg_n=7'h7F, dp_n=1, an_n=all 1, scan_idx=0, frame_tick=0, wr_ready=0. Shadow and active buffers are cleared to 0 with dp=0, and the dirty flag is cleared.
- wr_ready=1 from the first clock after reset release. It stays 1 regardless of enable.
- Write (valid&ready): shadow[wr_digit] <= {wr_dp, wr_data}, and dirty <= 1. If wr_digit >= NUM_DIGITS, the write is accepted and discarded, and dirty is unchanged.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: all outputs are off; slot counter = 0; scan_idx = 0. When enable=1, go to BLANK.
  - BLANK: an_n = all 1. seg_n/dp_n are driven with the pattern for scan_idx, so segments settle before the anode turns on. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: an_n[scan_idx]=0, others 1. After PRESCALE-BLANK_CYCLES cycles, advance scan_idx and go to BLANK. At wrap (NUM_DIGITS-1 -> 0), pulse frame_tick.
- Commit: in the frame_tick cycle, if dirty, active <= shadow and dirty <= 0.
  - A write in the same cycle lands in shadow after the copy. It re-sets dirty and is shown next frame.
- enable deasserted in any state: next cycle goes to IDLE and outputs go off. Re-enabling restarts at digit 0, BLANK, with counter 0.
- Outputs are registered: seg_n/dp_n/an_n change 1 cycle after the state or index change that causes them.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-frame: outputs go off immediately. The buffers are lost.

Optional Feature:
SEG_SCAN_BLINK_EN
- Defined: a free-running blink counter toggles a phase bit every BLINK_DIV cycles (phase=1 after reset). A digit with blink_mask bit 1 is forced blank (seg_n=7F, dp_n=1) while phase=0. Its anode is still scanned, so slot timing is unchanged.
- Undefined: there is no blink counter, and blink_mask is ignored (port kept).

Decomposition:
- Package seg_pkg holds: the 16-entry SEG_HEX_LUT constant (active-low, g..a), SEG_OFF=7'h7F, and the FSM state enum typedef scan_state_t.
- Sub-module seg_hex_decode: combinational 4-bit -> 7-bit active-low lookup from SEG_HEX_LUT. It is instantiated once on the scan path.

Test Plan:
1. Reset release, enable=0 -> seg_n=7F, an_n=F, wr_ready=1 after one clock.
2. N=4, PRESCALE=8, BLANK=2. Write digits 0..3 = 1,2,3,4, then enable=1.
   - After the first frame_tick, an_n walks E,D,B,7.
   - Each digit is low for 6 cycles, with a 2-cycle all-1 gap.
   - seg_n=1111001 while an_n=E.
3. Write digit 2 = F mid-frame -> the display still shows 3 until frame_tick, then shows 0001110 on digit 2 in the next frame.
4. Write coincident with the frame_tick cycle -> the old shadow is committed, the new value appears one frame later, and dirty remains 1.
5. enable dropped during SHOW on digit 2 -> next cycle an_n=F. Re-enable -> starts at digit 0 with the BLANK gap.
6. SEG_SCAN_BLINK_EN, BLINK_DIV=20, blink_mask=0001 -> digit 0 segments alternate lit/7F every 20 cycles; other digits stay steady.
